// File: rtl/alu_seq_exec.sv
// EX-stage ALU consuming the one-hot operation vector from the ALU control decoder.
// Shifts iterate one bit per cycle; all other operations finish in a single cycle.
module alu_seq_exec #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [25:0]           Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  branch_taken,
  output logic                  illegal_op
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_t;

  state_t                  state, state_nxt;
  shift_t                  sh_kind, sh_kind_nxt, op_kind;
  logic [SHAMT_WIDTH-1:0]  cnt, cnt_nxt, shamt;
  logic [DATA_WIDTH-1:0]   work, work_nxt, result_nxt, comb_res;
  logic                    op_ready_nxt, res_valid_nxt, branch_nxt, illegal_nxt;
  logic                    legal, is_shift, comb_br;

  function automatic logic [DATA_WIDTH-1:0] shift1(input shift_t k,
                                                  input logic [DATA_WIDTH-1:0] v);
    case (k)
      SH_SLL:  return {v[DATA_WIDTH-2:0], 1'b0};
      SH_SRL:  return {1'b0, v[DATA_WIDTH-1:1]};
      default: return {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
    endcase
  endfunction

  assign shamt = SrcB[SHAMT_WIDTH-1:0];

  // Operation decode and single-cycle result; ADD+SUB together is the legal SUB encoding
  always_comb begin
    legal    = ($onehot(Operation) && (Operation[25:17] == '0)) || (Operation == 26'h6);
    is_shift = legal && (Operation[6] || Operation[7] || Operation[8]);
    op_kind  = SH_SRA;
    if (Operation[8])      op_kind = SH_SLL;
    else if (Operation[7]) op_kind = SH_SRL;
    comb_res = '0;
    comb_br  = 1'b0;
    if (legal) begin
      if (Operation[2])       comb_res = SrcA - SrcB;
      else if (Operation[1])  comb_res = SrcA + SrcB;
      else if (Operation[0])  comb_res = SrcA | SrcB;
      else if (Operation[3])  comb_res = SrcA & SrcB;
      else if (Operation[4])  comb_res = SrcA ^ SrcB;
      else if (Operation[5])  comb_res = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
      else if (is_shift)      comb_res = (shamt == '0) ? SrcA : shift1(op_kind, SrcA);
      else if (Operation[13]) comb_res = SrcB;
      else if (Operation[14]) comb_res = DATA_WIDTH'(SrcA < SrcB);
      else if (Operation[9])  comb_br  = (SrcA == SrcB);
      else if (Operation[10]) comb_br  = (SrcA != SrcB);
      else if (Operation[11]) comb_br  = ($signed(SrcA) < $signed(SrcB));
      else if (Operation[12]) comb_br  = ($signed(SrcA) >= $signed(SrcB));
      else if (Operation[15]) comb_br  = (SrcA < SrcB);
      else if (Operation[16]) comb_br  = (SrcA >= SrcB);
    end
  end

  // Next state; the first shift happens on the accept edge so latency equals shamt
  always_comb begin
    state_nxt   = state;
    sh_kind_nxt = sh_kind;
    cnt_nxt     = cnt;
    work_nxt    = work;
    result_nxt  = ALUResult;
    branch_nxt  = branch_taken;
    illegal_nxt = illegal_op;
    case (state)
      IDLE: begin
        if (op_valid) begin
          if (is_shift && (shamt > SHAMT_WIDTH'(1))) begin
            state_nxt   = SHIFT;
            sh_kind_nxt = op_kind;
            cnt_nxt     = SHAMT_WIDTH'(shamt - SHAMT_WIDTH'(1));
            work_nxt    = shift1(op_kind, SrcA);
          end else begin
            state_nxt   = DONE;
            result_nxt  = comb_res;
            branch_nxt  = comb_br;
            illegal_nxt = !legal;
          end
        end
      end
      SHIFT: begin
        work_nxt = shift1(sh_kind, work);
        cnt_nxt  = SHAMT_WIDTH'(cnt - SHAMT_WIDTH'(1));
        if (cnt == SHAMT_WIDTH'(1)) begin
          state_nxt   = DONE;
          result_nxt  = shift1(sh_kind, work);
          branch_nxt  = 1'b0;
          illegal_nxt = 1'b0;
        end
      end
      DONE: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    op_ready_nxt  = (state_nxt == IDLE);
    res_valid_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      sh_kind      <= SH_SLL;
      cnt          <= '0;
      work         <= '0;
      op_ready     <= 1'b1;
      res_valid    <= 1'b0;
      ALUResult    <= '0;
      branch_taken <= 1'b0;
      illegal_op   <= 1'b0;
    end else begin
      state        <= state_nxt;
      sh_kind      <= sh_kind_nxt;
      cnt          <= cnt_nxt;
      work         <= work_nxt;
      op_ready     <= op_ready_nxt;
      res_valid    <= res_valid_nxt;
      ALUResult    <= result_nxt;
      branch_taken <= branch_nxt;
      illegal_op   <= illegal_nxt;
    end
  end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execution-side consumer of the one-hot 26-bit ALU operation vector produced by the ALU control decoder.
- Accepts operands and the operation vector through a valid/ready handshake and computes the result.
- Shifts run iteratively at one bit per cycle; every other operation completes in one cycle.
- Returns the result, a branch-taken flag and an illegal-operation flag through a second valid/ready handshake. Sits in the EX stage between the decoder and the writeback/branch logic.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SHAMT_WIDTH, 5, shift-amount bits taken from SrcB[SHAMT_WIDTH-1:0].

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- op_valid  input  1  operation request valid.
- op_ready  output  1  block can accept a request.
- Operation  input  26  one-hot operation select.
- SrcA  input  DATA_WIDTH  operand A.
- SrcB  input  DATA_WIDTH  operand B / shift amount.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- ALUResult  output  DATA_WIDTH  computed result.
- branch_taken  output  1  branch condition true.
- illegal_op  output  1  Operation not exactly one-hot.

Behaviour:
- Operation bit map:
  - 0 OR; 1 ADD; 2 SUB; 3 AND; 4 XOR; 5 SLT (signed); 6 SRA; 7 SRL; 8 SLL.
  - 9 BEQ; 10 BNE; 11 BLT (signed); 12 BGE (signed).
  - 13 PASSB (ALUResult=SrcB); 14 SLTU; 15 BLTU; 16 BGEU.
  - 17-25 reserved.
- Bit 2 set together with bit 1 is legal and means SUB; bit 1 alone means ADD. Any other multi-hot, zero-hot or reserved bit is illegal.
- Reset (async assert, sync deassert by the system): state=IDLE, op_ready=1, res_valid=0, ALUResult=0, branch_taken=0, illegal_op=0, internal shift counter=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - op_ready=1.
  - On op_valid: capture SrcA, SrcB and Operation.
  - Shift op with shamt>0 → SHIFT, counter loaded with shamt.
  - Otherwise compute the result in the same cycle, register it, → DONE.
- SHIFT:
  - op_ready=0.
  - Each cycle the working register shifts by 1 (SLL left with zero fill; SRL right with zero fill; SRA right with sign fill) and the counter decrements.
  - When the counter reaches 1, the final shift is applied → DONE.
  - Latency from accept to res_valid is shamt cycles; shamt=0 gives 1 cycle.
- DONE:
  - res_valid=1; outputs held stable while res_ready=0.
  - On res_ready=1 → IDLE; res_valid drops next cycle.
  - No new request is accepted in the DONE cycle; minimum throughput is one op per 2 cycles.
- Arithmetic:
  - ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow flag.
  - SLT/SLTU/branch compares use two's-complement or unsigned as named.
  - SLT/SLTU results are zero-extended 0/1.
- Branch ops (9-12, 15, 16): ALUResult=0, branch_taken=condition. All non-branch ops: branch_taken=0.
- Illegal op: ALUResult=0, branch_taken=0, illegal_op=1, latency 1. illegal_op is 0 for legal ops.
- Outputs are registered; they change only on entering DONE or on reset.
- Operand inputs are ignored after capture: changing SrcA/SrcB/Operation during SHIFT/DONE has no effect.
- Reset asserted mid-SHIFT or mid-DONE: immediate return to reset values; the in-flight op is discarded and no result is produced.

Test Plan:
- ADD: SrcA=0x7FFFFFFF, SrcB=1, Operation[1]=1 → res_valid 1 cycle after accept, ALUResult=0x80000000. SUB (bits 1+2): 5−7 → 0xFFFFFFFE.
- SRA: SrcA=0x80000000, SrcB=31 → res_valid exactly 31 cycles after accept, ALUResult=0xFFFFFFFF, op_ready=0 throughout. SLL by 0 → 1-cycle latency, result=SrcA.
- Branches:
  - BLT SrcA=0xFFFFFFFF, SrcB=1 → branch_taken=1, ALUResult=0.
  - BLTU same operands → branch_taken=0.
  - BEQ on equal operands → branch_taken=1.
- Backpressure: hold res_ready=0 for 10 cycles after an XOR 0xF0F0F0F0^0xFFFF0000 → ALUResult=0x0F0FF0F0 held stable, op_valid ignored; res_ready=1 → IDLE next cycle.
- Illegal: Operation=26'h0 and Operation=bits 0+3 → illegal_op=1, ALUResult=0, latency 1; reserved bit 20 → illegal_op=1.
- Reset: assert reset during SRL by 20 at cycle 8 → outputs return to reset values asynchronously; after release the next ADD 2+3 → 5 is correct.
